turf_round_ctrl: RTL
====================

TURF_ROUND_CTRL -- requirements
Module: turf_round_ctrl

Interface
REQ-001 Parameter ROUND_SECONDS, default 60, round length in sec_tick pulses (1..127).
REQ-002 Parameter SCAN_LAST, default 15'h4FF7, last linear frame-RAM address ({x=159, y=119}).
REQ-003 CLOCK_50  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-005 start  in  1  request a new round; sampled only in IDLE and DONE.
REQ-006 move_tick  in  1  one-cycle pulse per movement step.
REQ-007 sec_tick  in  1  one-cycle pulse per second.
REQ-008 p1, p2, p3, p4  in  15 each  player positions {x[7:0], y[6:0]}.
REQ-009 running  out  1  high only in PLAY and PAINT; gates the movement logic.
REQ-010 ram_address  out  15;  ram_data  out  3;  ram_wren  out  1  frame-RAM port.
REQ-011 ram_q  in  3  RAM read data, valid one cycle after ram_address is presented.
REQ-012 time_left  out  7  remaining seconds.
REQ-013 p1_count..p4_count  out  15 each  tallied cells per player.
REQ-014 winner  out  2;  winner_valid  out  1  result, valid in DONE only.

Function
REQ-015 States: IDLE, CLEAR, PLAY, PAINT, TALLY, DRAIN, DONE; start in IDLE or DONE moves to CLEAR on the next edge.
REQ-016 CLEAR: wren=1, data=000, address 0..SCAN_LAST, one per cycle; after SCAN_LAST, go to PLAY.
REQ-017 Counts zeroed, time_left=ROUND_SECONDS, and winner_valid=0 on CLEAR entry.
REQ-018 PLAY: wren=0, address=0; move_tick moves to PAINT.
REQ-019 PAINT: 4 consecutive write cycles with p1/001, p2/010, p3/100, p4/110 in that order; then back to PLAY.
REQ-020 move_tick during PAINT is ignored, with no queueing.
REQ-021 sec_tick in PLAY or PAINT decrements time_left; saturates at 0.
REQ-022 time_left==0 in PLAY moves to TALLY; a PAINT in progress always completes all 4 writes first.
REQ-023 TALLY: wren=0, address 0..SCAN_LAST, one per cycle; a registered valid flag tracks the 1-cycle read latency.
REQ-024 Each valid ram_q of 001/010/100/110 increments p1/p2/p3/p4_count; any other code is ignored.
REQ-025 DRAIN: one cycle accumulating ram_q for SCAN_LAST; then DONE.
REQ-026 Counts are 15 bits; the maximum 20472 cannot overflow; no wrap logic.
REQ-027 DONE: winner = index of the highest count; ties go to the lowest index (p1 over p2 over p3 over p4).
REQ-028 DONE: winner_valid=1; counts and winner are held until the next start.
REQ-029 start, move_tick and sec_tick are ignored in every state not listed above.

Reset
REQ-030 Reset asserted in any state: state=IDLE, running=0, wren=0, address=0, data=000.
REQ-031 Reset also forces counts=0, winner=00, winner_valid=0, time_left=ROUND_SECONDS.
REQ-032 A partial CLEAR or TALLY is abandoned by reset; no RAM write occurs while reset is high.

Configuration
REQ-033 Macro TURF_CLEAR_EN defined: CLEAR behaves as REQ-016.
REQ-034 TURF_CLEAR_EN undefined: start goes directly to PLAY (REQ-017 init still applied); RAM contents carry over between rounds.

Structure
REQ-035 Shared package turf_pkg holds the state enum, the player colour codes 001/010/100/110, SCAN_LAST, and the address field widths.
REQ-036 One sub-module turf_winner_cmp: combinational 4-way max with lowest-index tie-break, instantiated once.

Verification
REQ-037 Start with ROUND_SECONDS=2: exactly 20472 zero writes (addresses 0..0x4FF7), then running=1.
REQ-038 In PLAY with p1=0x4EF6, p2=0x0082, p3=0x4E82, p4=0x00F6, pulse move_tick: writes 0x4EF6/001, 0x0082/010, 0x4E82/100, 0x00F6/110 on 4 consecutive cycles.
REQ-039 Second move_tick during PAINT: still exactly 4 writes.
REQ-040 sec_tick arrives on the 2nd PAINT cycle with time_left=1: remaining 2 writes complete, then TALLY.
REQ-041 RAM model preloaded with 10 cells 001, 10 cells 100, rest 000: p1_count=10, p3_count=10, winner=00, winner_valid=1.
REQ-042 Reset mid-TALLY at address 0x1000: IDLE with zero counts; a following start produces a correct full tally.

Source files
------------

// File: rtl/turf_pkg.sv
// Shared types and constants for the turf round controller: FSM states, player colour codes,
// frame-RAM address geometry and tally counter width.
package turf_pkg;

   localparam int unsigned XW    = 8;
   localparam int unsigned YW    = 7;
   localparam int unsigned AddrW = XW + YW;
   localparam int unsigned CntW  = 15;

   // Last linear frame-RAM address, {x=159, y=119}.
   localparam logic [AddrW-1:0] ScanLast = 15'h4FF7;

   localparam logic [2:0] ColNone = 3'b000;
   localparam logic [2:0] ColP1   = 3'b001;
   localparam logic [2:0] ColP2   = 3'b010;
   localparam logic [2:0] ColP3   = 3'b100;
   localparam logic [2:0] ColP4   = 3'b110;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StPlay,
      StPaint,
      StTally,
      StDrain,
      StDone
   } turf_state_e;

   function automatic logic [2:0] player_colour(input logic [1:0] idx);
      logic [2:0] col;
      unique case (idx)
         2'd0:    col = ColP1;
         2'd1:    col = ColP2;
         2'd2:    col = ColP3;
         default: col = ColP4;
      endcase
      return col;
   endfunction

endpackage

// File: rtl/turf_winner_cmp.sv
// Combinational 4-way maximum over the player tallies; on equal counts the lowest index wins.
module turf_winner_cmp
   import turf_pkg::*;
(
   input  logic [CntW-1:0] c1_i,
   input  logic [CntW-1:0] c2_i,
   input  logic [CntW-1:0] c3_i,
   input  logic [CntW-1:0] c4_i,
   output logic [1:0]      win_o
);

   logic [CntW-1:0] best;

   // Strict greater-than keeps the earlier player on ties.
   always_comb begin
      best  = c1_i;
      win_o = 2'd0;
      if (c2_i > best) begin
         best  = c2_i;
         win_o = 2'd1;
      end
      if (c3_i > best) begin
         best  = c3_i;
         win_o = 2'd2;
      end
      if (c4_i > best) begin
         win_o = 2'd3;
      end
   end

endmodule

// File: rtl/turf_round_ctrl.sv
// Round controller for the turf game: clears the frame RAM, paints player cells on move ticks,
// counts down the round, tallies painted cells and reports the winner. TURF_CLEAR_EN adds CLEAR.
module turf_round_ctrl
   import turf_pkg::*;
#(
   parameter int unsigned      ROUND_SECONDS = 60,
   parameter logic [AddrW-1:0] SCAN_LAST     = ScanLast
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             start,
   input  logic             move_tick,
   input  logic             sec_tick,
   input  logic [AddrW-1:0] p1,
   input  logic [AddrW-1:0] p2,
   input  logic [AddrW-1:0] p3,
   input  logic [AddrW-1:0] p4,
   output logic             running,
   output logic [AddrW-1:0] ram_address,
   output logic [2:0]       ram_data,
   output logic             ram_wren,
   input  logic [2:0]       ram_q,
   output logic [6:0]       time_left,
   output logic [CntW-1:0]  p1_count,
   output logic [CntW-1:0]  p2_count,
   output logic [CntW-1:0]  p3_count,
   output logic [CntW-1:0]  p4_count,
   output logic [1:0]       winner,
   output logic             winner_valid
);

   localparam logic [6:0] TimeInit = 7'(ROUND_SECONDS);

   turf_state_e      state_q;
   logic             running_q;
   logic             wren_q;
   logic [AddrW-1:0] addr_q;
   logic [2:0]       data_q;
   logic [6:0]       time_q;
   logic [CntW-1:0]  cnt_q [4];
   logic [CntW-1:0]  cnt_d [4];
   logic [1:0]       winner_q;
   logic             winner_valid_q;
   logic [1:0]       paint_idx_q;
   logic             rd_valid_q;

   logic [1:0]       paint_nxt;
   logic [AddrW-1:0] pos_nxt;
   logic [1:0]       win_nxt;
   logic             acc_en;

   assign acc_en    = rd_valid_q && (state_q == StTally || state_q == StDrain);
   assign paint_nxt = paint_idx_q + 2'd1;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = cnt_q[i];
         if (acc_en && ram_q == player_colour(2'(i))) begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end
      end
   end

   always_comb begin
      unique case (paint_nxt)
         2'd1:    pos_nxt = p2;
         2'd2:    pos_nxt = p3;
         2'd3:    pos_nxt = p4;
         default: pos_nxt = p1;
      endcase
   end

   // Fed with the next-state tallies so the DRAIN edge registers a winner that includes SCAN_LAST.
   turf_winner_cmp u_winner_cmp (
      .c1_i  (cnt_d[0]),
      .c2_i  (cnt_d[1]),
      .c3_i  (cnt_d[2]),
      .c4_i  (cnt_d[3]),
      .win_o (win_nxt)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q        <= StIdle;
         running_q      <= 1'b0;
         wren_q         <= 1'b0;
         addr_q         <= '0;
         data_q         <= ColNone;
         time_q         <= TimeInit;
         for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
         winner_q       <= 2'd0;
         winner_valid_q <= 1'b0;
         paint_idx_q    <= 2'd0;
         rd_valid_q     <= 1'b0;
      end else begin
         if ((state_q == StPlay || state_q == StPaint) && sec_tick && time_q != 7'd0) begin
            time_q <= time_q - 7'd1;
         end
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  time_q         <= TimeInit;
                  for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
                  winner_q       <= 2'd0;
                  winner_valid_q <= 1'b0;
`ifdef TURF_CLEAR_EN
                  state_q        <= StClear;
                  wren_q         <= 1'b1;
                  addr_q         <= '0;
                  data_q         <= ColNone;
`else
                  state_q        <= StPlay;
                  running_q      <= 1'b1;
`endif
               end
            end
            StClear: begin
               if (addr_q == SCAN_LAST) begin
                  state_q   <= StPlay;
                  wren_q    <= 1'b0;
                  addr_q    <= '0;
                  running_q <= 1'b1;
               end else begin
                  addr_q <= addr_q + AddrW'(1);
               end
            end
            StPlay: begin
               if (time_q == 7'd0) begin
                  state_q    <= StTally;
                  running_q  <= 1'b0;
                  addr_q     <= '0;
                  rd_valid_q <= 1'b0;
               end else if (move_tick) begin
                  state_q     <= StPaint;
                  wren_q      <= 1'b1;
                  addr_q      <= p1;
                  data_q      <= ColP1;
                  paint_idx_q <= 2'd0;
               end
            end
            StPaint: begin
               if (paint_idx_q == 2'd3) begin
                  state_q <= StPlay;
                  wren_q  <= 1'b0;
                  addr_q  <= '0;
                  data_q  <= ColNone;
               end else begin
                  paint_idx_q <= paint_nxt;
                  addr_q      <= pos_nxt;
                  data_q      <= player_colour(paint_nxt);
               end
            end
            StTally: begin
               rd_valid_q <= 1'b1;
               cnt_q      <= cnt_d;
               if (addr_q == SCAN_LAST) begin
                  state_q <= StDrain;
                  addr_q  <= '0;
               end else begin
                  addr_q <= addr_q + AddrW'(1);
               end
            end
            StDrain: begin
               cnt_q          <= cnt_d;
               rd_valid_q     <= 1'b0;
               winner_q       <= win_nxt;
               winner_valid_q <= 1'b1;
               state_q        <= StDone;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign running      = running_q;
   assign ram_address  = addr_q;
   assign ram_data     = data_q;
   assign ram_wren     = wren_q;
   assign time_left    = time_q;
   assign p1_count     = cnt_q[0];
   assign p2_count     = cnt_q[1];
   assign p3_count     = cnt_q[2];
   assign p4_count     = cnt_q[3];
   assign winner       = winner_q;
   assign winner_valid = winner_valid_q;

endmodule
